// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared types for the cache DMA to memory bridge
package bp_me_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WR_COLLECT = 3'd1,
        WR_SEND    = 3'd2,
        WR_ACK     = 3'd3,
        RD_SEND    = 3'd4,
        RD_WAIT    = 3'd5,
        RD_STREAM  = 3'd6
    } bp_me_dma_state_e;

endpackage

// File: rtl/bsg_cache_pkg.sv
// rtl/bsg_cache_pkg.sv - L2 cache DMA packet format
package bsg_cache_pkg;

    // Widest physical address carried by a DMA packet; narrower users zero-extend.
    localparam int bsg_cache_dma_addr_width_gp = 64;

    typedef struct packed {
        logic                                   write_not_read;
        logic [bsg_cache_dma_addr_width_gp-1:0] addr;
    } bsg_cache_dma_pkt_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// rtl/bsg_counter_clear_up.sv - up counter with synchronous clear
module bsg_counter_clear_up #(
    parameter int width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    // Clear has priority over increment so the last word wraps cleanly to zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (up_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_me_cache_dma_to_mem.sv
// rtl/bp_me_cache_dma_to_mem.sv - L2 cache DMA port to block memory request/response bridge
// Optional: BP_ME_DMA_WRITE_ACK_EN makes a write wait for one memory response beat.
module bp_me_cache_dma_to_mem
    import bp_me_pkg::*;
    import bsg_cache_pkg::*;
#(
    parameter int paddr_width_p         = 40,
    parameter int dword_width_p         = 64,
    parameter int block_size_in_words_p = 8
) (
    input  logic                                           clk_i,
    input  logic                                           reset_n_i,

    input  logic [paddr_width_p:0]                         dma_pkt_i,
    input  logic                                           dma_pkt_v_i,
    output logic                                           dma_pkt_yumi_o,

    input  logic [dword_width_p-1:0]                       dma_data_i,
    input  logic                                           dma_data_v_i,
    output logic                                           dma_data_yumi_o,

    output logic [dword_width_p-1:0]                       dma_data_o,
    output logic                                           dma_data_v_o,
    input  logic                                           dma_data_ready_i,

    output logic                                           mem_req_v_o,
    input  logic                                           mem_req_ready_i,
    output logic                                           mem_req_w_o,
    output logic [paddr_width_p-1:0]                       mem_req_addr_o,
    output logic [dword_width_p*block_size_in_words_p-1:0] mem_req_data_o,

    input  logic                                           mem_resp_v_i,
    input  logic [dword_width_p*block_size_in_words_p-1:0] mem_resp_data_i,
    output logic                                           mem_resp_yumi_o
);

    localparam int block_width_lp    = dword_width_p * block_size_in_words_p;
    localparam int lg_words_lp       = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;
    localparam int lg_block_bytes_lp = $clog2((dword_width_p / 8) * block_size_in_words_p);
    localparam logic [paddr_width_p-1:0] offset_mask_lp = paddr_width_p'((64'd1 << lg_block_bytes_lp) - 64'd1);

    bp_me_dma_state_e          state_r, state_n;
    bsg_cache_dma_pkt_s        pkt_li;
    logic [paddr_width_p-1:0]  addr_r;
    logic [block_width_lp-1:0] buffer_r;
    logic [lg_words_lp-1:0]    cnt;
    logic                      cnt_adv;
    logic                      last_word;
    logic                      unused_addr_hi;

    assign pkt_li = '{write_not_read: dma_pkt_i[paddr_width_p],
                      addr:           bsg_cache_dma_addr_width_gp'(dma_pkt_i[paddr_width_p-1:0])};
    assign unused_addr_hi = ^pkt_li.addr[bsg_cache_dma_addr_width_gp-1:paddr_width_p];

    assign last_word      = (cnt == lg_words_lp'(block_size_in_words_p - 1));
    assign mem_req_addr_o = addr_r;
    assign mem_req_data_o = buffer_r;
    assign dma_data_o     = buffer_r[int'(cnt)*dword_width_p +: dword_width_p];

    bsg_counter_clear_up #(
        .width_p (lg_words_lp)
    ) word_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (cnt_adv & last_word),
        .up_i      (cnt_adv & ~last_word),
        .count_o   (cnt)
    );

    // State register; reset drops any in-flight transaction.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_n         = state_r;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        dma_data_v_o    = 1'b0;
        mem_req_v_o     = 1'b0;
        mem_req_w_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        cnt_adv         = 1'b0;
        case (state_r)
            IDLE: begin
                // Gated by reset so nothing is accepted while held in reset.
                if (dma_pkt_v_i && reset_n_i) begin
                    dma_pkt_yumi_o = 1'b1;
                    state_n        = pkt_li.write_not_read ? WR_COLLECT : RD_SEND;
                end
            end
            WR_COLLECT: begin
                dma_data_yumi_o = dma_data_v_i;
                cnt_adv         = dma_data_v_i;
                if (dma_data_v_i && last_word) begin
                    state_n = WR_SEND;
                end
            end
            WR_SEND: begin
                mem_req_v_o = 1'b1;
                mem_req_w_o = 1'b1;
                if (mem_req_ready_i) begin
`ifdef BP_ME_DMA_WRITE_ACK_EN
                    state_n = WR_ACK;
`else
                    state_n = IDLE;
`endif
                end
            end
            WR_ACK: begin
`ifdef BP_ME_DMA_WRITE_ACK_EN
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    state_n = IDLE;
                end
`else
                state_n = IDLE;
`endif
            end
            RD_SEND: begin
                mem_req_v_o = 1'b1;
                if (mem_req_ready_i) begin
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    state_n = RD_STREAM;
                end
            end
            RD_STREAM: begin
                dma_data_v_o = 1'b1;
                cnt_adv      = dma_data_ready_i;
                if (dma_data_ready_i && last_word) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Block-aligned address captured when a packet is accepted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_r <= '0;
        end else if (dma_pkt_yumi_o) begin
            addr_r <= pkt_li.addr[paddr_width_p-1:0] & ~offset_mask_lp;
        end
    end

    // Block buffer: filled word by word on writes, all at once on reads; not reset.
    always_ff @(posedge clk_i) begin
        if (state_r == WR_COLLECT && dma_data_v_i) begin
            buffer_r[int'(cnt)*dword_width_p +: dword_width_p] <= dma_data_i;
        end else if (state_r == RD_WAIT && mem_resp_v_i) begin
            buffer_r <= mem_resp_data_i;
        end
    end

endmodule

// File: tb/tb_bp_me_cache_dma_to_mem.sv
// tb/tb_bp_me_cache_dma_to_mem.sv - scoreboard bench for the cache DMA to memory bridge
module tb_bp_me_cache_dma_to_mem;

    localparam int PW = 40;
    localparam int DW = 64;
    localparam int NW = 8;
    localparam int BW = DW * NW;

    typedef struct packed {
        logic          w;
        logic [PW-1:0] addr;
        logic [BW-1:0] data;
    } req_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [PW:0]   dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_yumi_o;
    logic [DW-1:0] dma_data_i;
    logic          dma_data_v_i;
    logic          dma_data_yumi_o;
    logic [DW-1:0] dma_data_o;
    logic          dma_data_v_o;
    logic          dma_data_ready_i = 1'b1;
    logic          mem_req_v_o;
    logic          mem_req_ready_i = 1'b1;
    logic          mem_req_w_o;
    logic [PW-1:0] mem_req_addr_o;
    logic [BW-1:0] mem_req_data_o;
    logic          mem_resp_v_i;
    logic [BW-1:0] mem_resp_data_i;
    logic          mem_resp_yumi_o;

    req_t          exp_req_q[$];
    word_t         exp_word_q[$];
    logic [BW-1:0] mem_blk_q[$];

    int  n_cmp = 0;
    int  n_fail = 0;
    int  stall_left = 0;
    bit  toggle_ready = 1'b0;
    bit  busy = 1'b0;
    bit  cur_w = 1'b0;

    always #5 clk = ~clk;

    bp_me_cache_dma_to_mem #(
        .paddr_width_p         (PW),
        .dword_width_p         (DW),
        .block_size_in_words_p (NW)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .dma_pkt_i        (dma_pkt_i),
        .dma_pkt_v_i      (dma_pkt_v_i),
        .dma_pkt_yumi_o   (dma_pkt_yumi_o),
        .dma_data_i       (dma_data_i),
        .dma_data_v_i     (dma_data_v_i),
        .dma_data_yumi_o  (dma_data_yumi_o),
        .dma_data_o       (dma_data_o),
        .dma_data_v_o     (dma_data_v_o),
        .dma_data_ready_i (dma_data_ready_i),
        .mem_req_v_o      (mem_req_v_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_w_o      (mem_req_w_o),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_data_o   (mem_req_data_o),
        .mem_resp_v_i     (mem_resp_v_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_yumi_o  (mem_resp_yumi_o)
    );

    task automatic cmp(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] blk_of(input logic [DW-1:0] base);
        logic [BW-1:0] b;
        for (int i = 0; i < NW; i++) b[i*DW +: DW] = base + DW'(i);
        return b;
    endfunction

    // Monitor: every output handshake is checked against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset_n_i) begin
            cmp("reset_outputs_low", BW'({dma_pkt_yumi_o, dma_data_yumi_o, dma_data_v_o, mem_req_v_o, mem_resp_yumi_o}), '0);
            busy = 1'b0;
        end else begin
            if (dma_pkt_v_i && busy) cmp("pkt_yumi_while_busy", BW'(dma_pkt_yumi_o), '0);
            if (dma_pkt_yumi_o && !busy) begin
                busy  = 1'b1;
                cur_w = dma_pkt_i[PW];
            end
            if (mem_req_v_o) begin
                if (exp_req_q.size() == 0) begin
                    cmp("unexpected_mem_req", BW'(mem_req_v_o), '0);
                end else begin
                    req_t e;
                    e = exp_req_q[0];
                    cmp("mem_req_w", BW'(mem_req_w_o), BW'(e.w));
                    cmp("mem_req_addr", BW'(mem_req_addr_o), BW'(e.addr));
                    if (e.w) cmp("mem_req_data", mem_req_data_o, e.data);
                    if (mem_req_ready_i) begin
                        void'(exp_req_q.pop_front());
`ifndef BP_ME_DMA_WRITE_ACK_EN
                        if (e.w) busy = 1'b0;
`endif
                    end
                end
            end
            if (dma_data_v_o && dma_data_ready_i) begin
                if (exp_word_q.size() == 0) begin
                    cmp("unexpected_dma_word", BW'(dma_data_v_o), '0);
                end else begin
                    word_t ew;
                    ew = exp_word_q.pop_front();
                    cmp("dma_data_o", BW'(dma_data_o), BW'(ew.d));
                    if (ew.last) busy = 1'b0;
                end
            end
`ifdef BP_ME_DMA_WRITE_ACK_EN
            if (mem_resp_yumi_o && cur_w) busy = 1'b0;
`endif
        end
    end

    // Memory request backpressure: hold ready low for stall_left cycles of a pending request.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_v_o && stall_left > 0) begin
                mem_req_ready_i = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready_i = 1'b1;
            end
        end
    end

    // Fill-side consumer readiness.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            dma_data_ready_i = toggle_ready ? ~dma_data_ready_i : 1'b1;
        end
    end

    task automatic resp_beat(input logic [BW-1:0] data);
        bit got;
        got = 1'b0;
        #1;
        mem_resp_data_i = data;
        mem_resp_v_i    = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (mem_resp_yumi_o) got = 1'b1;
        end
        if (!got) cmp("resp_yumi_timeout", '0, BW'(1));
        @(posedge clk);
        #1;
        mem_resp_v_i = 1'b0;
    endtask

    // Memory responder: returns the next queued block two cycles after a read request.
    initial begin
        mem_resp_v_i    = 1'b0;
        mem_resp_data_i = '0;
        forever begin
            @(negedge clk);
            if (reset_n_i && mem_req_v_o && mem_req_ready_i) begin
                logic req_w;
                req_w = mem_req_w_o;
                @(posedge clk);
                if (!req_w) begin
                    logic [BW-1:0] b;
                    b = '0;
                    if (mem_blk_q.size() == 0) cmp("mem_blk_q_empty", '0, BW'(1));
                    else b = mem_blk_q.pop_front();
                    repeat (2) @(posedge clk);
                    resp_beat(b);
                end
`ifdef BP_ME_DMA_WRITE_ACK_EN
                else begin
                    repeat (10) @(posedge clk);
                    resp_beat({(BW/4){4'h5}});
                end
`endif
            end
        end
    end

    task automatic send_pkt(input logic w, input logic [PW-1:0] addr);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        dma_pkt_i   = {w, addr};
        dma_pkt_v_i = 1'b1;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            if (dma_pkt_yumi_o) got = 1'b1;
        end
        if (!got) cmp("pkt_yumi_timeout", '0, BW'(1));
        @(posedge clk);
        #1;
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic send_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            bit got;
            got = 1'b0;
            dma_data_i   = base + DW'(i);
            dma_data_v_i = 1'b1;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (dma_data_yumi_o) got = 1'b1;
            end
            if (!got) cmp("data_yumi_timeout", '0, BW'(1));
            @(posedge clk);
            #1;
        end
        dma_data_v_i = 1'b0;
    endtask

    task automatic do_read(input logic [PW-1:0] pkt_addr, input logic [PW-1:0] exp_addr, input logic [DW-1:0] base);
        exp_req_q.push_back('{w: 1'b0, addr: exp_addr, data: '0});
        mem_blk_q.push_back(blk_of(base));
        for (int i = 0; i < NW; i++) exp_word_q.push_back('{d: base + DW'(i), last: (i == NW - 1)});
        send_pkt(1'b0, pkt_addr);
    endtask

    task automatic do_write(input logic [PW-1:0] pkt_addr, input logic [PW-1:0] exp_addr, input logic [DW-1:0] base);
        exp_req_q.push_back('{w: 1'b1, addr: exp_addr, data: blk_of(base)});
        send_pkt(1'b1, pkt_addr);
        send_words(base, NW);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            #1;
            if (!busy && exp_req_q.size() == 0 && exp_word_q.size() == 0 && mem_blk_q.size() == 0) done = 1'b1;
        end
        if (!done) cmp("drain_timeout", '0, BW'(1));
    endtask

    initial begin
        reset_n_i    = 1'b0;
        dma_pkt_i    = '0;
        dma_pkt_v_i  = 1'b0;
        dma_data_i   = '0;
        dma_data_v_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n_i = 1'b1;

        // Plain read, unaligned packet address.
        do_read(40'h00_8000_0044, 40'h00_8000_0040, 64'h10);
        wait_idle();

        // Plain write.
        do_write(40'h00_8000_0080, 40'h00_8000_0080, 64'hA0);
        wait_idle();

        // Write with request backpressure.
        stall_left = 5;
        do_write(40'h00_8000_00C4, 40'h00_8000_00C0, 64'hB0);
        wait_idle();

        // Read with request backpressure and a toggling fill consumer.
        toggle_ready = 1'b1;
        stall_left   = 5;
        do_read(40'h00_8000_0104, 40'h00_8000_0100, 64'h20);
        wait_idle();
        toggle_ready = 1'b0;

        // Second packet offered while a read is in flight.
        do_read(40'h00_8000_0140, 40'h00_8000_0140, 64'h30);
        do_read(40'h00_8000_01BF, 40'h00_8000_0180, 64'h40);
        wait_idle();

        // Reset while collecting write word 3; the aborted write must never be issued.
        send_pkt(1'b1, 40'h00_8000_0200);
        send_words(64'hC0, 3);
        @(posedge clk);
        #1;
        dma_data_i   = 64'hC3;
        dma_data_v_i = 1'b1;
        reset_n_i    = 1'b0;
        #1;
        cmp("reset_outputs_immediate", BW'({dma_pkt_yumi_o, dma_data_yumi_o, dma_data_v_o, mem_req_v_o, mem_resp_yumi_o}), '0);
        dma_data_v_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n_i = 1'b1;
        do_write(40'h00_8000_0240, 40'h00_8000_0240, 64'hD0);
        wait_idle();
        do_read(40'h00_8000_0288, 40'h00_8000_0280, 64'h50);
        wait_idle();

        // Write immediately followed by a read packet.
        do_write(40'h00_8000_02C8, 40'h00_8000_02C0, 64'hE0);
        do_read(40'h00_8000_0300, 40'h00_8000_0300, 64'h60);
        wait_idle();

        repeat (3) @(posedge clk);
        cmp("exp_req_drained", BW'(exp_req_q.size()), '0);
        cmp("exp_word_drained", BW'(exp_word_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
